minimig_sram_responder: RTL and testbench
=========================================

MINIMIG_SRAM_RESPONDER -- requirements
Module: minimig_sram_responder

Interface
REQ-001 SHALL have parameter AW, default 22, meaning word-address width (address[AW:1]).
REQ-002 SHALL have parameter DW, default 16, meaning data width.
REQ-003 SHALL have port clk  in  1  the single system clock; all logic is on the rising edge.
REQ-004 SHALL have port _reset  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have ports _bhe, _ble, _we, _oe  in  1 each  SRAM-style active-low strobes from the chipset bridge.
REQ-006 SHALL have port address  in  AW  word address.
REQ-007 SHALL have port data  in  DW  write data from the bridge.
REQ-008 SHALL have port ramdata_out  out  DW  read data returned to the bridge.
REQ-009 SHALL have ports mem_req, mem_we  out  1  backing-memory request and write qualifier.
REQ-010 SHALL have ports mem_addr  out  AW, mem_wdata  out  DW, mem_be  out  2  backing-memory address, write data and byte enables ({hi,lo}).
REQ-011 SHALL have ports mem_ack  in  1, mem_rdata  in  DW  backing-memory completion pulse and read data.
REQ-012 SHALL have port busy  out  1  high while a backing request is outstanding.

Function
REQ-013 SHALL detect a write when _we=0 and (_bhe=0 or _ble=0), and a read when _oe=0 and _we=1; write SHALL win if _we and _oe are both low.
REQ-014 SHALL register strobes, address and data once per clk; access start = access present and (previous cycle idle, or address differs from captured address, or type differs from captured type).
REQ-015 SHALL use FSM states IDLE, RD, WR, DONE; IDLE/DONE -> RD or WR on start; RD/WR -> DONE on mem_ack; DONE -> IDLE when no access is present.
REQ-016 SHALL assert mem_req, and hold it with stable mem_addr/mem_we/mem_wdata/mem_be, from the cycle after start until the cycle mem_ack is sampled high (inclusive); it SHALL deassert the cycle after ack.
REQ-017 SHALL drive mem_be={~_bhe,~_ble} captured at start for writes, and 2'b11 for reads.
REQ-018 SHALL load ramdata_out from mem_rdata on read ack and hold it until the next read ack.
REQ-019 SHALL ignore strobe/address changes while in RD/WR; an access that ends before ack SHALL NOT abort the request, and the read result SHALL still be latched.
REQ-020 SHALL ignore mem_ack in IDLE and DONE.
REQ-021 SHALL, in DONE, start a new access on the next cycle when the bridge changes address or type without an idle gap.
REQ-022 SHALL drive busy=1 exactly in RD and WR.

Reset
REQ-023 SHALL, on _reset low, immediately force IDLE with mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, ramdata_out=0 and busy=0, independent of clk.
REQ-024 SHALL drop any outstanding request on reset without waiting for ack, and SHALL ignore an ack arriving after reset.

Configuration
REQ-025 SHALL implement a one-entry read-hit register when MINIMIG_SRAM_RESP_RDCACHE_EN is defined: tag=address and valid flag, set on read ack, cleared on any write ack and on reset.
REQ-026 SHALL, with the macro defined, treat a read start whose address matches a valid tag as a hit: no mem_req, go directly to DONE, ramdata_out unchanged.
REQ-027 SHALL, without the macro, issue mem_req for every read start and contain no tag logic.

Structure
REQ-028 SHALL place the FSM state typedef, default AW/DW constants and the byte-enable width in shared package minimig_sram_pkg.
REQ-029 SHALL implement strobe registration and start detection in sub-module minimig_sram_access_detect, which outputs start, is_write and the captured address, data and byte enables.

Verification
REQ-030 Read 0x012345 with mem_ack 3 cycles after mem_req and mem_rdata=0xBEEF -> mem_req high for exactly 3 cycles, mem_be=2'b11, ramdata_out=0xBEEF from the cycle after ack.
REQ-031 Write _bhe=0, _ble=1, data=0xA55A, address 0x000100 -> mem_we=1, mem_be=2'b10, mem_wdata=0xA55A, one request only.
REQ-032 Back-to-back reads 0x10 then 0x11 with no idle gap -> two requests, the second starting the cycle after DONE is entered.
REQ-033 _reset low while mem_req is high -> mem_req=0 and busy=0 immediately; a late mem_ack is ignored and ramdata_out stays 0.
REQ-034 With MINIMIG_SRAM_RESP_RDCACHE_EN, two reads to 0x20 -> one mem_req; read 0x20, write 0x20, read 0x20 -> three requests.
REQ-035 _we=0 and _oe=0 together with _ble=0 -> a write request is issued, not a read.

Source files
------------

// File: rtl/minimig_sram_pkg.sv
// Shared types and defaults for the Minimig SRAM responder.
package minimig_sram_pkg;

    localparam int AW_DEF = 22;
    localparam int DW_DEF = 16;
    localparam int BE_W   = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/minimig_sram_access_detect.sv
// Registers the bridge strobes and detects the start of a new access.
// The captured address/type/data/byte-enables double as the backing-memory
// request fields.
// They only update on an accepted start, so they remain stable while a
// request is outstanding.
module minimig_sram_access_detect
    import minimig_sram_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic            clk,
    input  logic            _reset,
    input  logic            _bhe,
    input  logic            _ble,
    input  logic            _we,
    input  logic            _oe,
    input  logic [AW-1:0]   address,
    input  logic [DW-1:0]   data,
    input  logic            accept,
    output logic            access,
    output logic            start,
    output logic            is_write,
    output logic [AW-1:0]   cur_addr,
    output logic [AW-1:0]   cap_addr,
    output logic            cap_we,
    output logic [DW-1:0]   cap_data,
    output logic [BE_W-1:0] cap_be
);

    logic          bhe_r, ble_r, we_r, oe_r;
    logic [AW-1:0] addr_r;
    logic [DW-1:0] data_r;
    logic          prev_access;
    logic          wr_now, rd_now;

    // Write wins when both _we and _oe are low.
    assign wr_now   = ~we_r & (~bhe_r | ~ble_r);
    assign rd_now   = ~oe_r & we_r;
    assign access   = wr_now | rd_now;
    assign is_write = wr_now;
    assign cur_addr = addr_r;
    assign start    = access & (~prev_access | (addr_r != cap_addr) | (wr_now != cap_we));

    // One-cycle registration of the bridge pins and of the previous access flag.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            bhe_r       <= 1'b1;
            ble_r       <= 1'b1;
            we_r        <= 1'b1;
            oe_r        <= 1'b1;
            addr_r      <= '0;
            data_r      <= '0;
            prev_access <= 1'b0;
        end else begin
            bhe_r       <= _bhe;
            ble_r       <= _ble;
            we_r        <= _we;
            oe_r        <= _oe;
            addr_r      <= address;
            data_r      <= data;
            prev_access <= access;
        end
    end

    // Capture the access fields only when the FSM is able to take a start.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            cap_addr <= '0;
            cap_we   <= 1'b0;
            cap_data <= '0;
            cap_be   <= '0;
        end else if (start && accept) begin
            cap_addr <= addr_r;
            cap_we   <= wr_now;
            cap_data <= data_r;
            cap_be   <= wr_now ? {~bhe_r, ~ble_r} : {BE_W{1'b1}};
        end
    end

endmodule

// File: rtl/minimig_sram_responder.sv
// SRAM-style bridge responder that turns strobe accesses into single
// backing-memory requests.
// Optional one-entry read-hit register: define MINIMIG_SRAM_RESP_RDCACHE_EN.
module minimig_sram_responder
    import minimig_sram_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic            clk,
    input  logic            _reset,
    input  logic            _bhe,
    input  logic            _ble,
    input  logic            _we,
    input  logic            _oe,
    input  logic [AW-1:0]   address,
    input  logic [DW-1:0]   data,
    output logic [DW-1:0]   ramdata_out,
    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [BE_W-1:0] mem_be,
    input  logic            mem_ack,
    input  logic [DW-1:0]   mem_rdata,
    output logic            busy
);

    state_t        state, state_nx;
    logic          access, start, is_write, accept, hit;
    logic [AW-1:0] cur_addr;

    minimig_sram_access_detect #(.AW(AW), .DW(DW)) u_detect (
        .clk      (clk),
        ._reset   (_reset),
        ._bhe     (_bhe),
        ._ble     (_ble),
        ._we      (_we),
        ._oe      (_oe),
        .address  (address),
        .data     (data),
        .accept   (accept),
        .access   (access),
        .start    (start),
        .is_write (is_write),
        .cur_addr (cur_addr),
        .cap_addr (mem_addr),
        .cap_we   (mem_we),
        .cap_data (mem_wdata),
        .cap_be   (mem_be)
    );

    // Starts are only taken outside an outstanding request.
    assign accept  = (state == IDLE) || (state == DONE);
    assign busy    = (state == RD) || (state == WR);
    assign mem_req = busy;

`ifdef MINIMIG_SRAM_RESP_RDCACHE_EN
    logic          tag_vld;
    logic [AW-1:0] tag;

    // Remember the last address read from memory; any write completion invalidates.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            tag_vld <= 1'b0;
            tag     <= '0;
        end else if (state == RD && mem_ack) begin
            tag_vld <= 1'b1;
            tag     <= mem_addr;
        end else if (state == WR && mem_ack) begin
            tag_vld <= 1'b0;
        end
    end

    assign hit = tag_vld && (tag == cur_addr);
`else
    logic unused_cur_addr;
    assign unused_cur_addr = ^cur_addr;
    assign hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) state <= IDLE;
        else         state <= state_nx;
    end

    // Next state: acks only matter in RD/WR; read hits skip memory.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: begin
                if (start)
                    state_nx = is_write ? WR : (hit ? DONE : RD);
                else if (state == DONE && !access)
                    state_nx = IDLE;
            end
            RD, WR: begin
                if (mem_ack) state_nx = DONE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Read data holds until the next read completion.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset)                    ramdata_out <= '0;
        else if (state == RD && mem_ack) ramdata_out <= mem_rdata;
    end

endmodule

// File: tb/tb_minimig_sram_responder.sv
// Bench for minimig_sram_responder: backing-memory model with a request log,
// expected requests queued at stimulus time and checked on completion.
module tb_minimig_sram_responder;

    localparam int AW = 22;
    localparam int DW = 16;

    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] wdata;
        logic [1:0]    be;
        logic [DW-1:0] rdata;
    } exp_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] wdata;
        logic [1:0]    be;
        int            len;
        int            start;
        bit            unstable;
    } obs_t;

    logic          clk = 1'b0;
    logic          _reset = 1'b0;
    logic          _bhe = 1'b1, _ble = 1'b1, _we = 1'b1, _oe = 1'b1;
    logic [AW-1:0] address = '0;
    logic [DW-1:0] data = '0;
    logic [DW-1:0] ramdata_out;
    logic          mem_req, mem_we, busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [1:0]    mem_be;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata;

    int   n_tests = 0, n_fail = 0;
    exp_t exp_q[$];
    obs_t obs[$];
    int   rd_idx = 0;
    int   lat = 3;
    bit   model_en = 1'b1;
    bit   force_ack = 1'b0;
    int   cycle = 0;
    int   cnt = 0;

    minimig_sram_responder #(.AW(AW), .DW(DW)) dut (
        .clk         (clk),
        ._reset      (_reset),
        ._bhe        (_bhe),
        ._ble        (_ble),
        ._we         (_we),
        ._oe         (_oe),
        .address     (address),
        .data        (data),
        .ramdata_out (ramdata_out),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_be      (mem_be),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
        if (a == 22'h012345) return 16'hBEEF;
        return a[15:0] ^ 16'hC3C3;
    endfunction

    assign mem_rdata = mem_f(mem_addr);

    // Memory model: logs each request, flags field changes, acks after lat cycles.
    always @(negedge clk) begin
        obs_t o;
        cycle++;
        if (mem_req) begin
            if (cnt == 0) begin
                o.addr = mem_addr; o.we = mem_we; o.wdata = mem_wdata; o.be = mem_be;
                o.len = 0; o.start = cycle; o.unstable = 1'b0;
                obs.push_back(o);
            end else if (mem_addr !== obs[obs.size()-1].addr || mem_we !== obs[obs.size()-1].we ||
                         mem_wdata !== obs[obs.size()-1].wdata || mem_be !== obs[obs.size()-1].be) begin
                obs[obs.size()-1].unstable = 1'b1;
            end
            cnt++;
            obs[obs.size()-1].len = cnt;
        end else begin
            cnt = 0;
        end
        mem_ack = model_en ? (mem_req && cnt == lat) : force_ack;
    end

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic bus_idle();
        _bhe = 1'b1; _ble = 1'b1; _we = 1'b1; _oe = 1'b1;
    endtask

    task automatic bus_read(input logic [AW-1:0] a);
        address = a; _we = 1'b1; _oe = 1'b0; _bhe = 1'b0; _ble = 1'b0;
    endtask

    task automatic bus_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic bhe, input logic ble);
        address = a; data = d; _we = 1'b0; _oe = 1'b1; _bhe = bhe; _ble = ble;
    endtask

    task automatic wait_reqs(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            step(1);
            if (obs.size() >= target && !mem_req) ok = 1'b1;
        end
    endtask

    task automatic wait_req_high(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            step(1);
            if (mem_req) ok = 1'b1;
        end
    endtask

    task automatic push_exp(input logic [AW-1:0] a, input logic we, input logic [DW-1:0] wd,
                            input logic [1:0] be, input logic [DW-1:0] rd);
        exp_t e;
        e.addr = a; e.we = we; e.wdata = wd; e.be = be; e.rdata = rd;
        exp_q.push_back(e);
    endtask

    task automatic resync();
        rd_idx = obs.size();
        exp_q.delete();
    endtask

    task automatic test_reset();
        step(2);
        n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req got %b want 0", mem_req); end
        n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we got %b want 0", mem_we); end
        n_tests++; if (mem_addr !== '0) begin n_fail++; $display("FAIL rst_mem_addr got %h want 0", mem_addr); end
        n_tests++; if (mem_wdata !== '0) begin n_fail++; $display("FAIL rst_mem_wdata got %h want 0", mem_wdata); end
        n_tests++; if (mem_be !== 2'b00) begin n_fail++; $display("FAIL rst_mem_be got %b want 00", mem_be); end
        n_tests++; if (ramdata_out !== '0) begin n_fail++; $display("FAIL rst_ramdata got %h want 0", ramdata_out); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
        _reset = 1'b1;
        step(2);
    endtask

    task automatic test_read();
        exp_t e; obs_t o; bit ok;
        lat = 3;
        push_exp(22'h012345, 1'b0, '0, 2'b11, 16'hBEEF);
        bus_read(22'h012345);
        wait_reqs(rd_idx + 1, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL read_timeout no completed request"); resync(); end
        else begin
            e = exp_q.pop_front(); o = obs[rd_idx]; rd_idx++;
            n_tests++; if (o.addr !== e.addr) begin n_fail++; $display("FAIL read_addr got %h want %h", o.addr, e.addr); end
            n_tests++; if (o.we !== e.we) begin n_fail++; $display("FAIL read_we got %b want %b", o.we, e.we); end
            n_tests++; if (o.be !== e.be) begin n_fail++; $display("FAIL read_be got %b want %b", o.be, e.be); end
            n_tests++; if (o.len != 3) begin n_fail++; $display("FAIL read_req_len got %0d want 3", o.len); end
            n_tests++; if (o.unstable) begin n_fail++; $display("FAIL read_stable got unstable want stable"); end
            n_tests++; if (ramdata_out !== e.rdata) begin n_fail++; $display("FAIL read_data got %h want %h", ramdata_out, e.rdata); end
            n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL read_busy_after got %b want 0", busy); end
        end
        bus_idle();
        step(3);
    endtask

    task automatic test_write();
        exp_t e; obs_t o; bit ok;
        lat = 2;
        push_exp(22'h000100, 1'b1, 16'hA55A, 2'b10, '0);
        bus_write(22'h000100, 16'hA55A, 1'b0, 1'b1);
        wait_reqs(rd_idx + 1, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL write_timeout no completed request"); resync(); end
        else begin
            e = exp_q.pop_front(); o = obs[rd_idx]; rd_idx++;
            n_tests++; if (o.addr !== e.addr) begin n_fail++; $display("FAIL write_addr got %h want %h", o.addr, e.addr); end
            n_tests++; if (o.we !== e.we) begin n_fail++; $display("FAIL write_we got %b want %b", o.we, e.we); end
            n_tests++; if (o.be !== e.be) begin n_fail++; $display("FAIL write_be got %b want %b", o.be, e.be); end
            n_tests++; if (o.wdata !== e.wdata) begin n_fail++; $display("FAIL write_wdata got %h want %h", o.wdata, e.wdata); end
            n_tests++; if (o.unstable) begin n_fail++; $display("FAIL write_stable got unstable want stable"); end
        end
        step(5);
        n_tests++; if (obs.size() != rd_idx) begin n_fail++; $display("FAIL write_single got %0d reqs want %0d", obs.size(), rd_idx); end
        n_tests++; if (ramdata_out !== 16'hBEEF) begin n_fail++; $display("FAIL write_keeps_rdata got %h want beef", ramdata_out); end
        bus_idle();
        step(3);
        resync();
    endtask

    task automatic test_write_wins();
        exp_t e; obs_t o; bit ok;
        push_exp(22'h000200, 1'b1, 16'h1234, 2'b01, '0);
        address = 22'h000200; data = 16'h1234; _we = 1'b0; _oe = 1'b0; _ble = 1'b0; _bhe = 1'b1;
        wait_reqs(rd_idx + 1, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL wewins_timeout no completed request"); resync(); end
        else begin
            e = exp_q.pop_front(); o = obs[rd_idx]; rd_idx++;
            n_tests++; if (o.we !== e.we) begin n_fail++; $display("FAIL wewins_we got %b want %b", o.we, e.we); end
            n_tests++; if (o.be !== e.be) begin n_fail++; $display("FAIL wewins_be got %b want %b", o.be, e.be); end
            n_tests++; if (o.wdata !== e.wdata) begin n_fail++; $display("FAIL wewins_wdata got %h want %h", o.wdata, e.wdata); end
        end
        bus_idle();
        step(3);
        resync();
    endtask

    task automatic test_back_to_back();
        exp_t e1, e2; obs_t o1, o2; bit ok;
        lat = 2;
        push_exp(22'h000010, 1'b0, '0, 2'b11, mem_f(22'h000010));
        bus_read(22'h000010);
        wait_req_high(ok);
        // Address moves on while the first request is still outstanding.
        push_exp(22'h000011, 1'b0, '0, 2'b11, mem_f(22'h000011));
        bus_read(22'h000011);
        if (ok) wait_reqs(rd_idx + 2, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL b2b_timeout requests did not complete"); resync(); end
        else begin
            e1 = exp_q.pop_front(); e2 = exp_q.pop_front();
            o1 = obs[rd_idx]; o2 = obs[rd_idx+1]; rd_idx += 2;
            n_tests++; if (o1.addr !== e1.addr) begin n_fail++; $display("FAIL b2b_addr1 got %h want %h", o1.addr, e1.addr); end
            n_tests++; if (o1.len != lat || o1.unstable) begin n_fail++; $display("FAIL b2b_req1 got len %0d unstable %0d want len %0d stable", o1.len, o1.unstable, lat); end
            n_tests++; if (o2.addr !== e2.addr) begin n_fail++; $display("FAIL b2b_addr2 got %h want %h", o2.addr, e2.addr); end
            n_tests++; if (o2.start - o1.start != lat + 1) begin n_fail++; $display("FAIL b2b_gap got %0d want %0d", o2.start - o1.start, lat + 1); end
            n_tests++; if (ramdata_out !== e2.rdata) begin n_fail++; $display("FAIL b2b_data got %h want %h", ramdata_out, e2.rdata); end
        end
        step(4);
        n_tests++; if (obs.size() != rd_idx) begin n_fail++; $display("FAIL b2b_count got %0d want %0d", obs.size(), rd_idx); end
        bus_idle();
        step(3);
        resync();
    endtask

    task automatic test_abandoned_read();
        exp_t e; obs_t o; bit ok;
        lat = 4;
        push_exp(22'h000030, 1'b0, '0, 2'b11, mem_f(22'h000030));
        bus_read(22'h000030);
        wait_req_high(ok);
        bus_idle();
        if (ok) wait_reqs(rd_idx + 1, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL abandon_timeout request did not complete"); resync(); end
        else begin
            e = exp_q.pop_front(); o = obs[rd_idx]; rd_idx++;
            n_tests++; if (o.len != 4) begin n_fail++; $display("FAIL abandon_len got %0d want 4", o.len); end
            n_tests++; if (ramdata_out !== e.rdata) begin n_fail++; $display("FAIL abandon_data got %h want %h", ramdata_out, e.rdata); end
        end
        step(3);
        resync();
    endtask

    task automatic test_reset_mid();
        bit ok;
        lat = 10;
        push_exp(22'h000040, 1'b0, '0, 2'b11, mem_f(22'h000040));
        bus_read(22'h000040);
        wait_req_high(ok);
        step(1);
        _reset = 1'b0;
        #1;
        n_tests++; if (!ok || mem_req !== 1'b0) begin n_fail++; $display("FAIL rstmid_req got %b (seen %0d) want 0", mem_req, ok); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", busy); end
        bus_idle();
        step(2);
        _reset = 1'b1;
        step(1);
        model_en = 1'b0;
        force_ack = 1'b1;
        step(3);
        force_ack = 1'b0;
        model_en = 1'b1;
        step(1);
        n_tests++; if (ramdata_out !== '0) begin n_fail++; $display("FAIL rstmid_late_ack got %h want 0", ramdata_out); end
        n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rstmid_req_after got %b want 0", mem_req); end
        resync();
    endtask

    task automatic test_rdcache();
        bit ok; int n0, n1;
        lat = 3;
        n0 = obs.size();
        push_exp(22'h000020, 1'b0, '0, 2'b11, mem_f(22'h000020));
        bus_read(22'h000020);
        wait_reqs(n0 + 1, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL cache_first_timeout no request"); end
        bus_idle(); step(3);
        bus_read(22'h000020);
        step(8);
        n1 = obs.size() - n0;
`ifdef MINIMIG_SRAM_RESP_RDCACHE_EN
        n_tests++; if (n1 != 1) begin n_fail++; $display("FAIL cache_hit_reqs got %0d want 1", n1); end
`else
        n_tests++; if (n1 != 2) begin n_fail++; $display("FAIL nocache_reqs got %0d want 2", n1); end
`endif
        n_tests++; if (ramdata_out !== exp_q[0].rdata) begin n_fail++; $display("FAIL cache_data got %h want %h", ramdata_out, exp_q[0].rdata); end
        bus_idle(); step(3);
        bus_write(22'h000020, 16'h7777, 1'b0, 1'b0);
        step(8);
        bus_idle(); step(3);
        bus_read(22'h000020);
        step(8);
        n1 = obs.size() - n0;
`ifdef MINIMIG_SRAM_RESP_RDCACHE_EN
        n_tests++; if (n1 != 3) begin n_fail++; $display("FAIL cache_rwr_reqs got %0d want 3", n1); end
`else
        n_tests++; if (n1 != 4) begin n_fail++; $display("FAIL nocache_rwr_reqs got %0d want 4", n1); end
`endif
        bus_idle(); step(3);
        resync();
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_write_wins();
        test_back_to_back();
        test_abandoned_read();
        test_reset_mid();
        test_rdcache();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
